program_loader: RTL and testbench



---
 rtl/program_loader_pkg.sv | 27 ++
 rtl/loader_word_assembler.sv | 33 +++
 rtl/program_loader.sv | 138 +++++++++++++
 tb/tb_program_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and widths for the instruction-memory loader
package program_loader_pkg;

  // Widths shared with the PC/fetch path
  localparam int IM_ADDR_W  = 8;
  localparam int IM_WORD_W  = 16;
  localparam int WORD_BYTES = 2;

  // A count byte of zero stands for a full memory image
  localparam int FULL_COUNT = 1 << IM_ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_HI,
    S_LO,
    S_WRITE,
    S_CHECK,
    S_FINISH
  } loader_state_t;

  // Word count meaning "all of memory" for an arbitrary address width
  function automatic int full_count(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - byte-to-word register plus instruction-memory write strobe
module loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int WORD_W = IM_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_hi,
  input  logic              i_load_lo,
  input  logic              i_write,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_we
);

  logic [WORD_W-1:0] r_word;

  // High byte arrives first, low byte second; the word holds still through the write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
    end else if (i_load_hi) begin
      r_word[WORD_W-1 -: 8] <= i_byte;
    end else if (i_load_lo) begin
      r_word[7:0] <= i_byte;
    end
  end

  assign o_word = r_word;
  assign o_we   = i_write;

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader into instruction memory (option: LOADER_CHECKSUM_EN)
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                ADDR_W    = IM_ADDR_W,
  parameter int                WORD_W    = IM_WORD_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [WORD_W-1:0] o_im_wdata,
  output logic              o_busy,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(full_count(ADDR_W));
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic              r_error;
  logic              w_in_ready;
  logic              w_xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  // Ready depends only on the registered state, never on in_valid
  assign w_in_ready = (r_state == S_COUNT) || (r_state == S_HI) ||
                      (r_state == S_LO)    || (r_state == S_CHECK);
  assign w_xfer     = i_in_valid && w_in_ready;

  // Load FSM: count byte, then hi/lo byte pairs, one write cycle per word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= BASE_ADDR;
      r_remaining <= '0;
      r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum      <= 8'h00;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_error <= 1'b0;
            r_addr  <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= 8'h00;
`endif
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_xfer) begin
            r_remaining <= (i_in_data == 8'h00) ? CNT_FULL : (ADDR_W+1)'(i_in_data);
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= r_csum ^ i_in_data;
`endif
            r_state     <= S_HI;
          end
        end
        S_HI: begin
          if (w_xfer) begin
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ i_in_data;
`endif
            r_state <= S_LO;
          end
        end
        S_LO: begin
          if (w_xfer) begin
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ i_in_data;
`endif
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_addr      <= r_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == CNT_ONE) begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= S_CHECK;
`else
            r_state <= S_FINISH;
`endif
          end else begin
            r_state <= S_HI;
          end
        end
        S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
          if (w_xfer) begin
            if (i_in_data != r_csum) r_error <= 1'b1;
            r_state <= S_FINISH;
          end
`else
          r_state <= S_FINISH;
`endif
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  loader_word_assembler #(
    .WORD_W(WORD_W)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .i_load_hi(w_xfer && (r_state == S_HI)),
    .i_load_lo(w_xfer && (r_state == S_LO)),
    .i_write  (r_state == S_WRITE),
    .i_byte   (i_in_data),
    .o_word   (o_im_wdata),
    .o_we     (o_im_we)
  );

  assign o_in_ready = w_in_ready;
  assign o_im_addr  = r_addr;
  assign o_busy     = (r_state != S_IDLE);
  assign o_cpu_hold = (r_state != S_IDLE);
  assign o_done     = (r_state == S_FINISH);
  assign o_error    = r_error;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_in_valid;
  logic [7:0]  i_in_data;
  logic        o_in_ready;
  logic        o_im_we;
  logic [7:0]  o_im_addr;
  logic [15:0] o_im_wdata;
  logic        o_busy;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;

`ifdef LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  program_loader dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_in_valid(i_in_valid),
    .i_in_data (i_in_data),
    .o_in_ready(o_in_ready),
    .o_im_we   (o_im_we),
    .o_im_addr (o_im_addr),
    .o_im_wdata(o_im_wdata),
    .o_busy    (o_busy),
    .o_cpu_hold(o_cpu_hold),
    .o_done    (o_done),
    .o_error   (o_error)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          busy_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          gap_drop = 0;
  logic [7:0]  wa[$];
  logic [15:0] wd[$];
  int          wc[$];
  logic [7:0]  tb_csum;

  // Observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (o_busy) busy_cnt++;
    if (o_im_we) begin
      wa.push_back(o_im_addr);
      wd.push_back(o_im_wdata);
      wc.push_back(cyc);
    end
    if (o_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_busy && !o_in_ready && !o_im_we && !o_done) gap_drop++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    busy_cnt = 0;
    done_cnt = 0;
    gap_drop = 0;
  endtask

  task automatic start_load();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    tb_csum = 8'h00;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      i_in_valid = 1'b0;
      @(negedge clk);
    end
    i_in_valid = 1'b1;
    i_in_data  = b;
    t = 0;
    while (!o_in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout: in_ready observed 0 expected 1");
    end
    @(negedge clk);
    tb_csum    = tb_csum ^ b;
    i_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (o_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $error("FAIL idle_timeout: busy observed 1 expected 0");
    end
  endtask

  task automatic end_load();
`ifdef LOADER_CHECKSUM_EN
    send(tb_csum, 0);
`endif
    wait_idle();
  endtask

  initial begin
    int errs;
    rst        = 1'b1;
    i_start    = 1'b0;
    i_in_valid = 1'b0;
    i_in_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_im_we",    o_im_we,    0);
    chk("rst_busy",     o_busy,     0);
    chk("rst_cpu_hold", o_cpu_hold, 0);
    chk("rst_done",     o_done,     0);
    chk("rst_error",    o_error,    0);
    chk("rst_im_addr",  o_im_addr,  8'h00);
    chk("rst_im_wdata", o_im_wdata, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Idle ignores bytes
    i_in_valid = 1'b1;
    i_in_data  = 8'h77;
    @(negedge clk);
    chk("idle_in_ready", o_in_ready, 0);
    chk("idle_busy",     o_busy,     0);
    i_in_valid = 1'b0;

    // Basic two-word load, valid always high
    clear_log();
    start_load();
    send(8'h02, 0); send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
    end_load();
    chk("basic_nwr",   wa.size(), 2);
    chk("basic_a0",    wa[0], 8'h00);
    chk("basic_d0",    wd[0], 16'h1234);
    chk("basic_a1",    wa[1], 8'h01);
    chk("basic_d1",    wd[1], 16'hABCD);
    chk("basic_done",  done_cnt, 1);
    chk("basic_dlat",  done_cyc, wc[1] + 1 + CK);
    chk("basic_busy",  busy_cnt, 8 + CK);
    chk("basic_error", o_error, 0);

    // Same stream with three idle cycles before every byte
    clear_log();
    start_load();
    send(8'h02, 3); send(8'h12, 3); send(8'h34, 3); send(8'hAB, 3); send(8'hCD, 3);
`ifdef LOADER_CHECKSUM_EN
    send(tb_csum, 3);
`endif
    wait_idle();
    chk("bp_nwr",  wa.size(), 2);
    chk("bp_a0",   wa[0], 8'h00);
    chk("bp_d0",   wd[0], 16'h1234);
    chk("bp_a1",   wa[1], 8'h01);
    chk("bp_d1",   wd[1], 16'hABCD);
    chk("bp_drop", gap_drop, 0);
    chk("bp_done", done_cnt, 1);
    chk("bp_addr", o_im_addr, 8'h02);

    // Full 256-word image, data equals address
    clear_log();
    start_load();
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      send(8'h00, 0);
      send(8'(i), 0);
    end
    end_load();
    errs = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== 8'(i) || wd[i] !== 16'(i)) errs++;
    end
    chk("full_nwr",  wa.size(), 256);
    chk("full_data", errs, 0);
    chk("full_wrap", o_im_addr, 8'h00);
    chk("full_done", done_cnt, 1);
    chk("full_busy", busy_cnt, 2 + 3 * 256 + CK);

    // Reset after the first word of a four-word load
    clear_log();
    start_load();
    send(8'h04, 0); send(8'h12, 0); send(8'h34, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy",     o_busy,     0);
    chk("mid_cpu_hold", o_cpu_hold, 0);
    chk("mid_im_we",    o_im_we,    0);
    chk("mid_nwr",      wa.size(),  1);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    start_load();
    send(8'h01, 0); send(8'h55, 0); send(8'h55, 0);
    end_load();
    chk("mid_new_nwr", wa.size(), 1);
    chk("mid_new_a0",  wa[0], 8'h00);
    chk("mid_new_d0",  wd[0], 16'h5555);

    // Start pulse during HI of a three-word load is ignored
    clear_log();
    start_load();
    send(8'h03, 0);
    i_start = 1'b1;
    send(8'h01, 0);
    i_start = 1'b0;
    send(8'h02, 0); send(8'h03, 0); send(8'h04, 0); send(8'h05, 0); send(8'h06, 0);
    end_load();
    chk("sb_nwr",   wa.size(), 3);
    chk("sb_a2",    wa[2], 8'h02);
    chk("sb_d2",    wd[2], 16'h0506);
    chk("sb_done",  done_cnt, 1);
    chk("sb_error", o_error, 0);

`ifdef LOADER_CHECKSUM_EN
    // Correct trailing checksum 01^12^34 = 27
    clear_log();
    start_load();
    send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h27, 0);
    wait_idle();
    chk("ck_good_error", o_error, 0);
    // Wrong trailing checksum sets error, done still pulses
    clear_log();
    start_load();
    send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h00, 0);
    wait_idle();
    chk("ck_bad_error", o_error, 1);
    chk("ck_bad_done",  done_cnt, 1);
    // Next accepted start clears error
    start_load();
    chk("ck_clear", o_error, 0);
    send(8'h01, 0); send(8'h00, 0); send(8'h00, 0);
    end_load();
    chk("ck_after", o_error, 0);
`else
    chk("nock_error", o_error, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
